// File: rtl/muldiv_hilo_if.sv
// ============================================================================
// Module   : muldiv_hilo_if
// Brief    : E-stage bus between the pipeline and the multiply/divide HI/LO unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface muldiv_hilo_if;
  logic        valid_i;
  logic        flush_i;
  logic [4:0]  alucontrol;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  modport slave (
    input  valid_i, flush_i, alucontrol, a_i, b_i,
    output stall_o, hi_o, lo_o, busy_o
  );

  modport master (
    output valid_i, flush_i, alucontrol, a_i, b_i,
    input  stall_o, hi_o, lo_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_hilo.sv
// ============================================================================
// Module   : muldiv_hilo
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU unit with the HI/LO register pair.
//            Optional macro DIV_ZERO_EARLY_EN: zero divisor skips the divide loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b01000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b01001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b01010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b01011
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b01100
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b01101
`endif

module muldiv_hilo #(
  parameter int DIV_ITER = 32
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_hilo_if.slave       bus
);

  localparam int                 c_CNT_W    = $clog2(DIV_ITER);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [63:0]         r_prod;
  logic [31:0]         r_rem;
  logic [31:0]         r_quo;
  logic [31:0]         r_divisor;
  logic [31:0]         r_a_orig;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dz;
  logic [c_CNT_W-1:0]  r_count;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;

  logic        w_op_ok;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed_div;
  logic        w_start;
  logic        w_div_zero;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_op_ok      = bus.valid_i & ~bus.flush_i;
  assign w_is_mul     = (bus.alucontrol == `MULT_CONTROL) | (bus.alucontrol == `MULTU_CONTROL);
  assign w_is_div     = (bus.alucontrol == `DIV_CONTROL)  | (bus.alucontrol == `DIVU_CONTROL);
  assign w_signed_div = (bus.alucontrol == `DIV_CONTROL);
  assign w_start      = w_op_ok & (r_state == S_IDLE) & (w_is_mul | w_is_div);
  assign w_div_zero   = (bus.b_i == 32'd0);

  assign w_prod = (bus.alucontrol == `MULT_CONTROL)
                ? 64'($signed({{32{bus.a_i[31]}}, bus.a_i}) * $signed({{32{bus.b_i[31]}}, bus.b_i}))
                : {32'd0, bus.a_i} * {32'd0, bus.b_i};

  assign w_abs_a = (w_signed_div & bus.a_i[31]) ? -bus.a_i : bus.a_i;
  assign w_abs_b = (w_signed_div & bus.b_i[31]) ? -bus.b_i : bus.b_i;

  // Restoring step: partial remainder stays below the divisor, so 33 bits suffice.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_is_mul) begin
            w_next = S_MUL;
          end else begin
`ifdef DIV_ZERO_EARLY_EN
            w_next = w_div_zero ? S_DIV_FIX : S_DIV_RUN;
`else
            w_next = S_DIV_RUN;
`endif
          end
        end
      end
      S_MUL:     w_next = S_IDLE;
      S_DIV_RUN: if (r_count == c_CNT_LAST) w_next = S_DIV_FIX;
      S_DIV_FIX: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (bus.flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod    <= 64'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_a_orig  <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_count   <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start & w_is_mul) r_prod <= w_prod;
          if (w_start & w_is_div) begin
            r_rem     <= 32'd0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_a_orig  <= bus.a_i;
            r_neg_q   <= w_signed_div & (bus.a_i[31] ^ bus.b_i[31]);
            r_neg_r   <= w_signed_div & bus.a_i[31];
            r_dz      <= w_div_zero;
            r_count   <= '0;
          end
          if (w_op_ok & (bus.alucontrol == `MTHI_CONTROL)) r_hi <= bus.a_i;
          if (w_op_ok & (bus.alucontrol == `MTLO_CONTROL)) r_lo <= bus.a_i;
        end
        S_MUL: begin
          if (!bus.flush_i) {r_hi, r_lo} <= r_prod;
        end
        S_DIV_RUN: begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_count <= r_count + 1'b1;
        end
        S_DIV_FIX: begin
          if (!bus.flush_i) begin
            if (r_dz) begin
              r_hi <= r_a_orig;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= r_neg_r ? -r_rem : r_rem;
              r_lo <= r_neg_q ? -r_quo : r_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // MUL and DIV_FIX drop the stall so the owning instruction leaves E as HI/LO is written.
  assign bus.stall_o = w_start | ((r_state == S_DIV_RUN) & ~bus.flush_i);
  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
// ============================================================================
// Module   : tb_muldiv_hilo
// Brief    : Directed self-checking bench for muldiv_hilo.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef MULT_CONTROL
`define MULT_CONTROL  5'b01000
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'b01001
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'b01010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'b01011
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'b01100
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'b01101
`endif

module tb_muldiv_hilo;

  localparam logic [4:0] c_NOP = 5'b11111;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;
  int   stalls;

  muldiv_hilo_if bus ();

  muldiv_hilo #(.DIV_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the instruction in E while stalled, then retires it; returns at the
  // first cycle after retirement, when HI/LO must already reflect the result.
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall);
    @(posedge clk); #1;
    bus.valid_i    = 1'b1;
    bus.alucontrol = c;
    bus.a_i        = a;
    bus.b_i        = b;
    n_stall        = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.stall_o) break;
      n_stall++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.valid_i    = 1'b0;
    bus.alucontrol = c_NOP;
  endtask

  initial begin
    n_vec          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.alucontrol = c_NOP;
    bus.a_i        = 32'd0;
    bus.b_i        = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi",    bus.hi_o, 32'd0);
    check("reset_lo",    bus.lo_o, 32'd0);
    check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    check("reset_busy",  {31'd0, bus.busy_o},  32'd0);
    rst = 1'b0;

    run_op(`MTHI_CONTROL, 32'h12345678, 32'd0, stalls);
    check("mthi_stall", stalls, 0);
    run_op(`MTLO_CONTROL, 32'h9ABCDEF0, 32'd0, stalls);
    check("mtlo_stall", stalls, 0);
    check("mthi_hi", bus.hi_o, 32'h12345678);
    check("mtlo_lo", bus.lo_o, 32'h9ABCDEF0);

    run_op(`MULT_CONTROL, 32'hFFFFFFFF, 32'd2, stalls);
    check("mult_stall", stalls, 1);
    check("mult_hi", bus.hi_o, 32'hFFFFFFFF);
    check("mult_lo", bus.lo_o, 32'hFFFFFFFE);

    run_op(`MULTU_CONTROL, 32'hFFFFFFFF, 32'd2, stalls);
    check("multu_stall", stalls, 1);
    check("multu_hi", bus.hi_o, 32'd1);
    check("multu_lo", bus.lo_o, 32'hFFFFFFFE);

    run_op(`DIV_CONTROL, 32'hFFFFFFF9, 32'd2, stalls);
    check("div_stall", stalls, 33);
    check("div_lo", bus.lo_o, 32'hFFFFFFFD);
    check("div_hi", bus.hi_o, 32'hFFFFFFFF);

    run_op(`DIV_CONTROL, 32'd7, 32'hFFFFFFFE, stalls);
    check("div_negb_lo", bus.lo_o, 32'hFFFFFFFD);
    check("div_negb_hi", bus.hi_o, 32'd1);

    run_op(`DIVU_CONTROL, 32'd100, 32'd7, stalls);
    check("divu_stall", stalls, 33);
    check("divu_lo", bus.lo_o, 32'd14);
    check("divu_hi", bus.hi_o, 32'd2);

    run_op(`DIVU_CONTROL, 32'd5, 32'd0, stalls);
`ifdef DIV_ZERO_EARLY_EN
    check("divz_stall", stalls, 1);
`else
    check("divz_stall", stalls, 33);
`endif
    check("divz_lo", bus.lo_o, 32'hFFFFFFFF);
    check("divz_hi", bus.hi_o, 32'd5);

    run_op(`DIV_CONTROL, 32'hFFFFFFF8, 32'd0, stalls);
    check("divz_s_lo", bus.lo_o, 32'hFFFFFFFF);
    check("divz_s_hi", bus.hi_o, 32'hFFFFFFF8);

    // Flush in the tenth DIV_RUN cycle.
    @(posedge clk); #1;
    bus.valid_i    = 1'b1;
    bus.alucontrol = `DIV_CONTROL;
    bus.a_i        = 32'd1000;
    bus.b_i        = 32'd3;
    #1;
    check("flush_accept_stall", {31'd0, bus.stall_o}, 32'd1);
    repeat (9) @(posedge clk);
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    #1;
    check("flush_stall", {31'd0, bus.stall_o}, 32'd0);
    check("flush_busy_during", {31'd0, bus.busy_o}, 32'd1);
    @(posedge clk); #1;
    bus.flush_i    = 1'b0;
    bus.valid_i    = 1'b0;
    bus.alucontrol = c_NOP;
    check("flush_busy_after", {31'd0, bus.busy_o}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi", bus.hi_o, 32'hFFFFFFF8);
    check("flush_lo", bus.lo_o, 32'hFFFFFFFF);

    // Reset in the middle of a division.
    @(posedge clk); #1;
    bus.valid_i    = 1'b1;
    bus.alucontrol = `DIV_CONTROL;
    bus.a_i        = 32'd1000;
    bus.b_i        = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.alucontrol = c_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstdiv_hi",    bus.hi_o, 32'd0);
    check("rstdiv_lo",    bus.lo_o, 32'd0);
    check("rstdiv_stall", {31'd0, bus.stall_o}, 32'd0);
    check("rstdiv_busy",  {31'd0, bus.busy_o},  32'd0);

    run_op(`MULT_CONTROL, 32'd3, 32'hFFFFFFFC, stalls);
    check("post_rst_mult_stall", stalls, 1);
    check("post_rst_mult_hi", bus.hi_o, 32'hFFFFFFFF);
    check("post_rst_mult_lo", bus.lo_o, 32'hFFFFFFF4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_hilo.md
# muldiv_hilo

Execute-stage multi-cycle multiply/divide unit with the architectural HI/LO register pair. It sits downstream of the ALU-control decoder and consumes the same 5-bit `alucontrol` code from `defines2.vh`. It acts on `MULT/MULTU/DIV/DIVU/MTHI/MTLO_CONTROL`, ignores every other code, and stalls the pipeline while an operation is in flight. `hi_o`/`lo_o` feed the MFHI/MFLO result path.

## Interface
- `DIV_ITER`, 32: radix-2 divider iterations; fixed at operand width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  E-stage instruction is valid (not a bubble).
- `flush_i`  in  1  exception flush; cancels any operation and suppresses HI/LO writes.
- `alucontrol`  in  5  decoded control code (`*_CONTROL` macros).
- `a_i`  in  32  rs operand (dividend, multiplicand, MTHI/MTLO data).
- `b_i`  in  32  rt operand (divisor, multiplier).
- `stall_o`  out  1  hold F/D/E stages.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.
- `busy_o`  out  1  FSM not in IDLE (debug/perf).

## Operation
- Define start = `valid_i & ~flush_i & state==IDLE & alucontrol ∈ {MULT, MULTU, DIV, DIVU}`.
- States: IDLE, MUL, DIV_RUN, DIV_FIX.
- IDLE:
  - MULT/MULTU: latch the 64-bit product of a_i and b_i (signed or unsigned) into a register, then go to MUL.
  - DIV/DIVU: latch |a|,|b| (raw values for DIVU) and the sign flags, clear count, then go to DIV_RUN.
  - MTHI: hi<=a_i. MTLO: lo<=a_i. Both only when `valid_i & ~flush_i`.
- MUL: {hi,lo}<=product at the end of the cycle; go to IDLE.
- DIV_RUN: one restoring shift-subtract step per cycle, then count++. At count==31, go to DIV_FIX.
- DIV_FIX: apply signs and write HI/LO; go to IDLE.
  - Signed: quotient negated if a[31]^b[31]; remainder negated if a[31].
  - Unsigned: no sign correction.
- Divide by zero (b_i==0): result is fixed at lo=32'hFFFFFFFF, hi=a_i (original, unsigned view), for both DIV and DIVU.
- `stall_o` = start | (state==DIV_RUN). It is combinational and low in MUL and DIV_FIX, so the owning instruction leaves E on the same edge that HI/LO is written.
- Flush in any state: next state is IDLE, no HI/LO write, `stall_o` low in that cycle. Flush takes priority over start, MTHI/MTLO and the final write.
- Control codes other than the six handled are ignored: no state change and no stall.

## Timing
- Reset: state=IDLE, count=0, hi_o=0, lo_o=0, stall_o=0, busy_o=0.
- Reset takes priority over flush and all operations, including mid-division.
- MULT/MULTU:
  - `stall_o` high for 1 cycle (accept cycle).
  - HI/LO update at the end of the MUL cycle; new value visible 2 cycles after the accept cycle begins.
- DIV/DIVU:
  - `stall_o` high for 33 cycles (accept + 32 DIV_RUN).
  - HI/LO written at the end of DIV_FIX; visible 34 cycles after accept.
- MTHI/MTLO: single cycle, no stall; visible the next cycle.
- A back-to-back mul/div is accepted in the first IDLE cycle after completion.
- There is no HI/LO read bypass: MFHI in the cycle of a write reads the old value. Hazard logic owns this case.

## Configuration
- `DIV_ZERO_EARLY_EN` defined: when divisor==0 at accept, go IDLE→DIV_FIX directly. `stall_o` is high for 1 cycle only and the result is written 2 cycles after accept.
- `DIV_ZERO_EARLY_EN` undefined: divide-by-zero runs the full 33-cycle stall, with the same result values.

## Test plan
- Reset then MTHI a=32'h12345678, next MTLO a=32'h9ABCDEF0 → hi_o=32'h12345678, lo_o=32'h9ABCDEF0, stall_o never high.
- MULT a=32'hFFFFFFFF(-1), b=2 → one stall cycle; hi=32'hFFFFFFFF, lo=32'hFFFFFFFE. MULTU with the same operands → hi=1, lo=32'hFFFFFFFE.
- DIV a=-7, b=2 → stall exactly 33 cycles; lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=5, b=0 → lo=32'hFFFFFFFF, hi=5. Stall is 1 cycle with `DIV_ZERO_EARLY_EN` defined, 33 cycles without.
- DIV started, flush_i at cycle 10 of DIV_RUN → stall_o drops that cycle, state IDLE next cycle, hi/lo unchanged.
- rst asserted mid-DIV_RUN → next cycle hi=lo=0, stall_o=0, busy_o=0. Then a MULT accepted immediately completes normally.
